io_rx_fifo: RTL and testbench



---
 rtl/io_fifo_pkg.sv | 10 +
 rtl/io_rx_fifo_strobe_sync.sv | 15 +
 rtl/io_rx_fifo.sv | 64 ++++++
 tb/tb_io_rx_fifo.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_fifo_pkg.sv
// io_fifo_pkg: shared defaults and level-width helpers for the IO byte FIFOs
package io_fifo_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF = 16;
  localparam int LVL_W_DEF = $clog2(DEPTH_DEF) + 1;
  typedef logic [LVL_W_DEF-1:0] lvl_t;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/io_rx_fifo_strobe_sync.sv
// strobe_sync: 3-flop synchronizer with rising-edge pulse for SPI-domain strobes
module strobe_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);
  logic s1, s2, s3;
  // shift the async strobe through the synchronizer chain
  always_ff @(posedge clk) begin
    if (!reset_n) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {async_in, s1, s2};
  end
  assign rise = s2 & ~s3;
endmodule

// File: rtl/io_rx_fifo.sv
// io_rx_fifo: strobe-resynchronised byte FIFO with FWFT valid/ready output; IO_RX_FIFO_STATS_EN adds drop_cnt
module io_rx_fifo
  import io_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              strobe_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW:0]       level,
  output logic              overflow,
  input  logic              clr
`ifdef IO_RX_FIFO_STATS_EN
  , output logic [7:0]      drop_cnt
`endif
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_req, pop, do_push, drop, full;
  strobe_sync u_sync (
    .clk(clk),
    .reset_n(reset_n),
    .async_in(strobe_in),
    .rise(push_req)
  );
  assign full = level[AW];
  assign out_valid = level != '0;
  assign out_data = out_valid ? mem[rd_ptr] : '0;
  assign pop = out_valid & out_ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push = push_req & (~full | pop) & ~clr;
  assign drop = push_req & full & ~pop & ~clr;
  // storage write; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end
  // pointers, occupancy and sticky overflow, flushed by reset or clr
  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      level <= level + (AW+1)'(do_push) - (AW+1)'(pop);
      overflow <= overflow | drop;
    end
  end
`ifdef IO_RX_FIFO_STATS_EN
  // saturating count of bytes lost to a full FIFO
  always_ff @(posedge clk) begin
    if (!reset_n || clr) drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_io_rx_fifo.sv
// tb_io_rx_fifo: directed self-checking bench for io_rx_fifo
module tb_io_rx_fifo;
  logic clk = 0, reset_n = 0, strobe_in = 0, out_ready = 0, clr = 0;
  logic [7:0] data_in = 0, out_data;
  logic out_valid, overflow;
  logic [4:0] level;
  int n_run = 0, n_fail = 0;
`ifdef IO_RX_FIFO_STATS_EN
  logic [7:0] drop_cnt;
`endif

  io_rx_fifo dut (
    .clk(clk), .reset_n(reset_n), .strobe_in(strobe_in), .data_in(data_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow), .clr(clr)
`ifdef IO_RX_FIFO_STATS_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] d);
    data_in = d;
    strobe_in = 1;
    tick(2);
    strobe_in = 0;
    tick(3);
  endtask

  task automatic flush();
    clr = 1;
    tick();
    clr = 0;
    tick(3);
  endtask

  task automatic test_reset();
    reset_n = 0;
    tick(2);
    n_run++;
    if (level !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: level=%0d valid=%b ovf=%b data=%h, want 0/0/0/00", level, out_valid, overflow, out_data);
    end
    reset_n = 1;
    tick(3);
  endtask

  task automatic test_single();
    data_in = 8'hA5;
    strobe_in = 1;
    tick(2);
    n_run++;
    if (level !== 5'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: level=%0d valid=%b, want 0/0 after 2 edges", level, out_valid);
    end
    tick();
    n_run++;
    if (level !== 5'd1 || out_valid !== 1'b1 || out_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_push: level=%0d valid=%b data=%h, want 1/1/a5", level, out_valid, out_data);
    end
    tick(3);
    strobe_in = 0;
    tick(3);
    n_run++;
    if (level !== 5'd1) begin
      n_fail++;
      $display("FAIL single_once: level=%0d, want 1", level);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    n_run++;
    if (level !== 5'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pop: level=%0d valid=%b, want 0/0", level, out_valid);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) strobe(8'(i));
    n_run++;
    if (level !== 5'd16 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fill: level=%0d ovf=%b, want 16/0", level, overflow);
    end
    strobe(8'h10);
    n_run++;
    if (level !== 5'd16 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: level=%0d ovf=%b, want 16/1", level, overflow);
    end
`ifdef IO_RX_FIFO_STATS_EN
    n_run++;
    if (drop_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL drop_cnt_one: got %0d, want 1", drop_cnt);
    end
`endif
    for (int i = 0; i < 16; i++) begin
      n_run++;
      if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        n_fail++;
        $display("FAIL drain[%0d]: valid=%b data=%h, want 1/%h", i, out_valid, out_data, 8'(i));
      end
      out_ready = 1;
      tick();
      out_ready = 0;
    end
    n_run++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL drained: valid=%b ovf=%b, want 0/1", out_valid, overflow);
    end
    flush();
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 16; i++) strobe(8'(8'h20 + i));
    data_in = 8'h55;
    strobe_in = 1;
    tick(2);
    out_ready = 1;
    tick();
    out_ready = 0;
    strobe_in = 0;
    tick(3);
    n_run++;
    if (level !== 5'd16 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop: level=%0d ovf=%b, want 16/0", level, overflow);
    end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = (i == 15) ? 8'h55 : 8'(8'h21 + i);
      n_run++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        n_fail++;
        $display("FAIL full_pop_drain[%0d]: valid=%b data=%h, want 1/%h", i, out_valid, out_data, exp);
      end
      out_ready = 1;
      tick();
      out_ready = 0;
    end
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_empty: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_stream();
    int got = 0, bad = 0, maxl = 0;
    out_ready = 1;
    for (int i = 0; i < 40; i++) begin
      data_in = 8'(8'h80 + i);
      for (int c = 0; c < 5; c++) begin
        strobe_in = c < 2;
        tick();
        if (int'(level) > maxl) maxl = int'(level);
        if (out_valid) begin
          if (out_data !== 8'(8'h80 + got)) bad++;
          got++;
        end
      end
    end
    strobe_in = 0;
    tick(4);
    out_ready = 0;
    n_run++;
    if (got != 40 || bad != 0) begin
      n_fail++;
      $display("FAIL stream_order: got=%0d bad=%0d, want 40/0", got, bad);
    end
    n_run++;
    if (maxl > 1) begin
      n_fail++;
      $display("FAIL stream_level: max=%0d, want <=1", maxl);
    end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 17; i++) strobe(8'(i));
    out_ready = 1;
    tick(11);
    out_ready = 0;
    n_run++;
    if (level !== 5'd5 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_setup: level=%0d ovf=%b, want 5/1", level, overflow);
    end
    data_in = 8'h77;
    strobe_in = 1;
    tick(2);
    clr = 1;
    tick();
    clr = 0;
    n_run++;
    if (level !== 5'd0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clr: level=%0d ovf=%b valid=%b, want 0/0/0", level, overflow, out_valid);
    end
    tick(3);
    strobe_in = 0;
    tick(3);
    n_run++;
    if (level !== 5'd0) begin
      n_fail++;
      $display("FAIL clr_norepush: level=%0d, want 0", level);
    end
`ifdef IO_RX_FIFO_STATS_EN
    n_run++;
    if (drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL drop_cnt_clr: got %0d, want 0", drop_cnt);
    end
    for (int i = 0; i < 316; i++) strobe(8'(i));
    n_run++;
    if (drop_cnt !== 8'd255 || level !== 5'd16) begin
      n_fail++;
      $display("FAIL drop_cnt_sat: got %0d level=%0d, want 255/16", drop_cnt, level);
    end
`endif
    flush();
  endtask

  task automatic test_reset_strobe();
    data_in = 8'h3C;
    strobe_in = 1;
    tick(2);
    reset_n = 0;
    tick(2);
    reset_n = 1;
    tick(2);
    n_run++;
    if (level !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_strobe_early: level=%0d, want 0", level);
    end
    tick();
    n_run++;
    if (level !== 5'd1 || out_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL rst_strobe_push: level=%0d data=%h, want 1/3c", level, out_data);
    end
    tick(6);
    n_run++;
    if (level !== 5'd1) begin
      n_fail++;
      $display("FAIL rst_strobe_held: level=%0d, want 1", level);
    end
    strobe_in = 0;
    tick(3);
    strobe(8'h3D);
    n_run++;
    if (level !== 5'd2) begin
      n_fail++;
      $display("FAIL rst_strobe_rerise: level=%0d, want 2", level);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_fill_drain();
    test_full_pop();
    test_stream();
    test_clr();
    test_reset_strobe();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
